word_rx_fifo: RTL and testbench

Parameterised byte-to-word assembler for the serial receive path. It collects `WORD_BYTES` bytes from the byte receiver and assembles them into one word, with the byte order selectable per word. Completed words go out over a valid/ready handshake from a one-entry holding register, so a slow consumer does not stall byte reception. An optional inter-byte timeout discards stale partial words.

---
 rtl/word_rx_fifo_if.sv | 27 ++
 rtl/word_rx_fifo.sv | 99 +++++++++
 tb/tb_word_rx_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/word_rx_fifo_if.sv
// Byte-in / word-out bus of the receive word assembler.
// The producer/consumer side uses master; the assembler uses slave.
interface word_rx_fifo_if #(
    parameter int WORD_BYTES = 4
);
    localparam int FW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [7:0]              in;
    logic                    byte_done;
    logic                    msb_first;
    logic [8*WORD_BYTES-1:0] out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overrun;
    logic                    timeout;
    logic [FW-1:0]           fill;

    modport master (
        output in, byte_done, msb_first, out_ready,
        input  out, out_valid, overrun, timeout, fill
    );

    modport slave (
        input  in, byte_done, msb_first, out_ready,
        output out, out_valid, overrun, timeout, fill
    );
endinterface

// File: rtl/word_rx_fifo.sv
// Byte-to-word assembler with per-word byte order and a one-entry output holding register.
// Optional inter-byte timeout is built only when WORD_RX_TIMEOUT_EN is defined.
module word_rx_fifo #(
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst,
    word_rx_fifo_if.slave  bus
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int FW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0]  r_acc;
    logic [FW-1:0] r_fill;
    logic          r_order;
    logic [W-1:0]  r_out;
    logic          r_out_valid;
    logic          r_overrun;
    logic          r_timeout;

    logic          w_order;
    logic [W-1:0]  w_word;
    logic          w_complete;
    logic          w_load;
    logic          w_expire;

    // The first byte of a word uses the live order bit; later bytes use the latched one.
    assign w_order    = (r_fill == '0) ? bus.msb_first : r_order;
    assign w_complete = bus.byte_done && (r_fill == FW'(WORD_BYTES - 1));
    assign w_load     = w_complete && (!r_out_valid || bus.out_ready);

    always_comb begin
        w_word = r_acc;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (bus.byte_done &&
                ((w_order ? (WORD_BYTES - 1 - i) : i) == int'(r_fill)))
                w_word[i*8 +: 8] = bus.in;
        end
    end

`ifdef WORD_RX_TIMEOUT_EN
    logic [CW-1:0] r_cnt;

    assign w_expire = (r_fill != '0) && !bus.byte_done &&
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (bus.byte_done || (r_fill == '0) || w_expire)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (CW > 0);
    assign w_expire     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_order     <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_overrun <= w_complete && r_out_valid && !bus.out_ready;
            r_timeout <= w_expire;

            if (bus.byte_done) begin
                r_acc  <= w_word;
                r_fill <= w_complete ? '0 : r_fill + FW'(1);
                if (r_fill == '0)
                    r_order <= bus.msb_first;
            end else if (w_expire) begin
                r_fill <= '0;
            end

            if (w_load) begin
                r_out       <= w_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.overrun   = r_overrun;
    assign bus.timeout   = r_timeout;
    assign bus.fill      = r_fill;
endmodule

// File: tb/tb_word_rx_fifo.sv
// Scoreboard bench for word_rx_fifo: stimulus queues expected words, a monitor checks each handshake.
module tb_word_rx_fifo;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic rst;

    word_rx_fifo_if #(.WORD_BYTES(WB)) bus ();

    word_rx_fifo #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ovr   = 0;
    int n_tmo   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the front of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.overrun) n_ovr++;
            if (bus.timeout) n_tmo++;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, expected none", bus.out);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.out !== e) begin
                        n_fail++;
                        $display("FAIL word: got %h, expected %h", bus.out, e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic m);
        bus.in        = b;
        bus.msb_first = m;
        bus.byte_done = 1'b1;
        @(posedge clk); #1;
        bus.byte_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in = 8'h00; bus.byte_done = 1'b0; bus.msb_first = 1'b0; bus.out_ready = 1'b0;
        #12;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out",   bus.out, 32'd0);
        check("rst_fill",  {30'd0, bus.fill}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LSB-first word, fill progression
        bus.out_ready = 1'b1;
        send(8'h11, 1'b0); check("fill1", {30'd0, bus.fill}, 32'd1);
        send(8'h22, 1'b0); check("fill2", {30'd0, bus.fill}, 32'd2);
        send(8'h33, 1'b0); check("fill3", {30'd0, bus.fill}, 32'd3);
        exp_q.push_back(32'h44332211);
        send(8'h44, 1'b0);
        check("fill0", {30'd0, bus.fill}, 32'd0);
        check("valid_after_last", {31'd0, bus.out_valid}, 32'd1);
        check("out_lsb", bus.out, 32'h44332211);
        idle(1);
        check("valid_one_cycle", {31'd0, bus.out_valid}, 32'd0);

        // MSB-first, order bit latched on the first byte only
        exp_q.push_back(32'hDEADBEEF);
        send(8'hDE, 1'b1); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
        idle(1);

        // Stalled consumer: second word dropped with one overrun pulse
        bus.out_ready = 1'b0;
        exp_q.push_back(32'h04030201);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
        check("overrun_pulse", {31'd0, bus.overrun}, 32'd1);
        check("out_held", bus.out, 32'h04030201);
        idle(1);
        check("overrun_clear", {31'd0, bus.overrun}, 32'd0);
        check("overrun_count", n_ovr, 32'd1);
        bus.out_ready = 1'b1;
        idle(1);
        check("valid_after_drain", {31'd0, bus.out_valid}, 32'd0);

        // Completion coinciding with drain: no bubble, no overrun
        bus.out_ready = 1'b0;
        exp_q.push_back(32'h40302010);
        send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
        exp_q.push_back(32'h80706050);
        send(8'h50, 1'b0); send(8'h60, 1'b0); send(8'h70, 1'b0);
        bus.out_ready = 1'b1;
        send(8'h80, 1'b0);
        check("swap_valid", {31'd0, bus.out_valid}, 32'd1);
        check("swap_out", bus.out, 32'h80706050);
        check("swap_no_overrun", {31'd0, bus.overrun}, 32'd0);
        idle(1);
        check("swap_drained", {31'd0, bus.out_valid}, 32'd0);
        check("overrun_count2", n_ovr, 32'd1);

        // Inter-byte timeout (or its absence in the default build)
        send(8'h5A, 1'b0); send(8'h5B, 1'b0);
        idle(8);
`ifdef WORD_RX_TIMEOUT_EN
        check("timeout_pulse", {31'd0, bus.timeout}, 32'd1);
        check("timeout_fill", {30'd0, bus.fill}, 32'd0);
        exp_q.push_back(32'hA4A3A2A1);
`else
        check("timeout_pulse", {31'd0, bus.timeout}, 32'd0);
        check("timeout_fill", {30'd0, bus.fill}, 32'd2);
        exp_q.push_back(32'hA2A15B5A);
`endif
        idle(1);
        check("timeout_clear", {31'd0, bus.timeout}, 32'd0);
        send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
        idle(1);
`ifdef WORD_RX_TIMEOUT_EN
        check("post_tmo_fill", {30'd0, bus.fill}, 32'd0);
        check("timeout_count", n_tmo, 32'd1);
`else
        check("post_tmo_fill", {30'd0, bus.fill}, 32'd2);
        check("timeout_count", n_tmo, 32'd0);
`endif

        // Normalise, then asynchronous reset mid-word with a word held
        rst = 1'b1; #1; @(posedge clk); #1; rst = 1'b0;
        bus.out_ready = 1'b0;
        send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        check("held_before_rst", {31'd0, bus.out_valid}, 32'd1);
        send(8'hD1, 1'b1); send(8'hD2, 1'b1); send(8'hD3, 1'b1);
        check("fill_before_rst", {30'd0, bus.fill}, 32'd3);
        #2; rst = 1'b1; #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_out", bus.out, 32'd0);
        check("arst_fill", {30'd0, bus.fill}, 32'd0);
        check("arst_pulses", {30'd0, bus.overrun, bus.timeout}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.push_back(32'hE4E3E2E1);
        send(8'hE1, 1'b0); send(8'hE2, 1'b0); send(8'hE3, 1'b0); send(8'hE4, 1'b0);
        check("post_rst_out", bus.out, 32'hE4E3E2E1);
        idle(3);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
